// File: rtl/resp_demux6_pkg.sv
// ============================================================================
// demux_pkg : shared select encoding and one-hot decode for the 6-way demux
// Rev 1.0
// ============================================================================
`default_nettype none

package demux_pkg;

  localparam int NUM_PORTS = 6;
  localparam int SEL_W     = 3;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_A = 3'd0;
  localparam sel_t SEL_B = 3'd1;
  localparam sel_t SEL_C = 3'd2;
  localparam sel_t SEL_D = 3'd3;
  localparam sel_t SEL_E = 3'd4;
  localparam sel_t SEL_F = 3'd5;

  // Codes 6 and 7 name no port, so they decode to no valid at all.
  function automatic logic [NUM_PORTS-1:0] onehot6(input sel_t sel);
    logic [NUM_PORTS-1:0] oh;
    oh = '0;
    if (sel <= SEL_F) oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/resp_demux6_if.sv
// ============================================================================
// resp_demux6_if : issue / response / per-port delivery bus of resp_demux6
// Rev 1.0
// ============================================================================
`default_nettype none

interface resp_demux6_if
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) ();

  logic                   req_issue;
  sel_t                   req_sel;
  logic                   tag_full;
  logic                   resp_valid;
  logic [WIDTH-1:0]       resp_data;
  logic [NUM_PORTS-1:0]   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic [$clog2(DEPTH):0] outstanding;
  logic                   err_orphan;
  logic                   err_badsel;

  modport master (
    output req_issue, req_sel, resp_valid, resp_data,
    input  tag_full, out_valid, out_data, outstanding, err_orphan, err_badsel
  );

  modport slave (
    input  req_issue, req_sel, resp_valid, resp_data,
    output tag_full, out_valid, out_data, outstanding, err_orphan, err_badsel
  );

endinterface

`default_nettype wire

// File: rtl/resp_demux6_tag_fifo.sv
// ============================================================================
// tag_fifo : synchronous FIFO of requester tags, push allowed when full if a
//            pop happens in the same cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module tag_fifo
  import demux_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = SEL_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [DW-1:0]          wdata_i,
  output logic [DW-1:0]          rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          w_push;
  logic          w_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && (!full_o || w_pop);

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (w_push) wptr_d = wptr_q + 1'b1;
    if (w_pop)  rptr_d = rptr_q + 1'b1;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/resp_demux6.sv
// ============================================================================
// resp_demux6 : routes in-order responses back to the issuing requester
//               using a FIFO of recorded selects
// Rev 1.0
// ============================================================================
`default_nettype none

module resp_demux6
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  resp_demux6_if.slave  bus
);

  logic                   w_sel_ok;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_empty;
  logic                   w_full;
  sel_t                   w_tag;
  logic [$clog2(DEPTH):0] w_count;

  logic [NUM_PORTS-1:0] out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic                 err_orphan_q, err_orphan_d;
  logic                 err_badsel_q, err_badsel_d;

  assign w_sel_ok = (bus.req_sel <= SEL_F);
  assign w_push   = bus.req_issue && w_sel_ok;
  // A tag pushed this cycle is not yet visible, so it cannot serve this response.
  assign w_pop    = bus.resp_valid && !w_empty;

  tag_fifo #(
    .DEPTH (DEPTH),
    .DW    (SEL_W)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (bus.req_sel),
    .rdata_o (w_tag),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  always_comb begin
    out_valid_d  = '0;
    out_data_d   = out_data_q;
    err_orphan_d = err_orphan_q | (bus.resp_valid & w_empty);
    err_badsel_d = err_badsel_q | (bus.req_issue & ~w_sel_ok);
    if (w_pop) begin
      out_valid_d = onehot6(w_tag);
      out_data_d  = bus.resp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= '0;
      out_data_q   <= '0;
      err_orphan_q <= 1'b0;
      err_badsel_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      err_orphan_q <= err_orphan_d;
      err_badsel_q <= err_badsel_d;
    end
  end

  assign bus.tag_full    = w_full;
  assign bus.outstanding = w_count;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.err_orphan  = err_orphan_q;
  assign bus.err_badsel  = err_badsel_q;

endmodule

`default_nettype wire

// File: tb/tb_resp_demux6.sv
// ============================================================================
// tb_resp_demux6 : depth-8 and depth-4 instances driven in lockstep against a
//                  queue-based reference model, plus directed sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_resp_demux6;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  resp_demux6_if #(.WIDTH(W), .DEPTH(8)) bus8 ();
  resp_demux6_if #(.WIDTH(W), .DEPTH(4)) bus4 ();

  resp_demux6 #(.WIDTH(W), .DEPTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  resp_demux6 #(.WIDTH(W), .DEPTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: one queue of tags per instance, index 0 = depth 8, 1 = depth 4.
  int          dep [2] = '{8, 4};
  int          q   [2][$];
  logic [5:0]  mv  [2];
  logic [31:0] md  [2];
  bit          meo [2];
  bit          meb [2];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic compare_model();
    logic [5:0]  av;
    logic [31:0] ad;
    int          ao;
    logic        af, aeo, aeb;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        av = bus8.out_valid; ad = bus8.out_data; ao = 32'(bus8.outstanding);
        af = bus8.tag_full;  aeo = bus8.err_orphan; aeb = bus8.err_badsel;
      end else begin
        av = bus4.out_valid; ad = bus4.out_data; ao = 32'(bus4.outstanding);
        af = bus4.tag_full;  aeo = bus4.err_orphan; aeb = bus4.err_badsel;
      end
      check($sformatf("d%0d_out_valid", dep[k]), 64'(av), 64'(mv[k]));
      check($sformatf("d%0d_out_data", dep[k]), 64'(ad), 64'(md[k]));
      check($sformatf("d%0d_outstanding", dep[k]), 64'(ao), 64'(q[k].size()));
      check($sformatf("d%0d_tag_full", dep[k]), 64'(af), 64'(q[k].size() == dep[k]));
      check($sformatf("d%0d_err_orphan", dep[k]), 64'(aeo), 64'(meo[k]));
      check($sformatf("d%0d_err_badsel", dep[k]), 64'(aeb), 64'(meb[k]));
    end
  endtask

  // Apply one cycle of inputs to both instances, advance the model, compare.
  task automatic step(input bit r, input bit iss, input logic [2:0] sel,
                      input bit rv, input logic [31:0] data);
    bit pop, push, orph;
    rst = r;
    bus8.req_issue = iss; bus8.req_sel = sel; bus8.resp_valid = rv; bus8.resp_data = data;
    bus4.req_issue = iss; bus4.req_sel = sel; bus4.resp_valid = rv; bus4.resp_data = data;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        q[k].delete();
        mv[k] = '0; md[k] = '0; meo[k] = 1'b0; meb[k] = 1'b0;
      end else begin
        orph = rv && (q[k].size() == 0);
        pop  = rv && (q[k].size() > 0);
        push = iss && (sel <= 3'd5) && ((q[k].size() < dep[k]) || pop);
        if (pop) begin
          mv[k] = 6'(1 << q[k][0]);
          md[k] = data;
          void'(q[k].pop_front());
        end else begin
          mv[k] = '0;
        end
        if (push) q[k].push_back(int'(sel));
        if (orph) meo[k] = 1'b1;
        if (iss && sel > 3'd5) meb[k] = 1'b1;
      end
    end
    #1;
    compare_model();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'd0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 3'd0, 1'b0, 32'h0);
  endtask

  typedef struct {
    bit          iss;
    logic [2:0]  sel;
    bit          rv;
    logic [31:0] data;
    logic [5:0]  ev;
    logic [31:0] ed;
    int          eo;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int exp_order [4];
    int s;

    // Test 1 table, expectations for the depth-8 instance.
    for (int i = 0; i < 6; i++)
      tbl[i] = '{iss: 1'b1, sel: 3'(i), rv: 1'b0, data: 32'h0, ev: 6'h0, ed: 32'h0, eo: i + 1};
    for (int i = 0; i < 6; i++)
      tbl[6+i] = '{iss: 1'b0, sel: 3'd0, rv: 1'b1, data: 32'h10 + 32'(i),
                   ev: 6'(1 << i), ed: 32'h10 + 32'(i), eo: 5 - i};
    tbl[12] = '{iss: 1'b0, sel: 3'd0, rv: 1'b0, data: 32'h0, ev: 6'h0, ed: 32'h15, eo: 0};

    rst = 1'b1;
    do_reset();
    do_reset();
    check("reset_out_valid", 64'(bus4.out_valid), 64'h0);
    check("reset_out_data", 64'(bus4.out_data), 64'h0);
    check("reset_flags", 64'({bus4.tag_full, bus4.err_orphan, bus4.err_badsel}), 64'h0);

    for (int i = 0; i < 13; i++) begin
      step(1'b0, tbl[i].iss, tbl[i].sel, tbl[i].rv, tbl[i].data);
      check($sformatf("t1_valid[%0d]", i), 64'(bus8.out_valid), 64'(tbl[i].ev));
      check($sformatf("t1_data[%0d]", i), 64'(bus8.out_data), 64'(tbl[i].ed));
      check($sformatf("t1_outstanding[%0d]", i), 64'(bus8.outstanding), 64'(tbl[i].eo));
    end

    // Full FIFO: push with same-cycle pop keeps the count at depth.
    do_reset();
    step(1'b0, 1'b1, 3'd5, 1'b0, 32'h0);
    step(1'b0, 1'b1, 3'd2, 1'b0, 32'h0);
    step(1'b0, 1'b1, 3'd5, 1'b0, 32'h0);
    step(1'b0, 1'b1, 3'd0, 1'b0, 32'h0);
    check("t2_full", 64'(bus4.tag_full), 64'h1);
    check("t2_outstanding4", 64'(bus4.outstanding), 64'd4);
    step(1'b0, 1'b1, 3'd3, 1'b1, 32'hAA);
    check("t2_valid", 64'(bus4.out_valid), 64'h20);
    check("t2_data", 64'(bus4.out_data), 64'hAA);
    check("t2_outstanding_hold", 64'(bus4.outstanding), 64'd4);
    exp_order = '{2, 5, 0, 3};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 3'd0, 1'b1, 32'hB0 + 32'(i));
      check($sformatf("t2_order[%0d]", i), 64'(bus4.out_valid), 64'(1 << exp_order[i]));
    end
    idle();
    check("t2_drained", 64'(bus4.outstanding), 64'd0);

    // Orphan response, then normal traffic still works.
    do_reset();
    step(1'b0, 1'b0, 3'd0, 1'b1, 32'hDEAD);
    check("t3_no_valid", 64'(bus4.out_valid), 64'h0);
    check("t3_orphan", 64'(bus4.err_orphan), 64'h1);
    step(1'b0, 1'b1, 3'd1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 3'd0, 1'b1, 32'h55);
    check("t3_valid", 64'(bus4.out_valid), 64'h02);
    check("t3_orphan_sticky", 64'(bus4.err_orphan), 64'h1);

    // Bad select pushes nothing.
    do_reset();
    step(1'b0, 1'b1, 3'd7, 1'b0, 32'h0);
    check("t4_badsel", 64'(bus4.err_badsel), 64'h1);
    check("t4_outstanding", 64'(bus4.outstanding), 64'd0);
    step(1'b0, 1'b0, 3'd0, 1'b1, 32'h77);
    check("t4_orphan", 64'(bus4.err_orphan), 64'h1);

    // Reset mid-operation discards tags and clears sticky errors.
    do_reset();
    step(1'b0, 1'b1, 3'd6, 1'b0, 32'h0);
    step(1'b0, 1'b1, 3'd4, 1'b0, 32'h0);
    step(1'b0, 1'b1, 3'd4, 1'b0, 32'h0);
    step(1'b0, 1'b1, 3'd1, 1'b0, 32'h0);
    check("t5_pre_outstanding", 64'(bus4.outstanding), 64'd3);
    do_reset();
    check("t5_outstanding", 64'(bus4.outstanding), 64'd0);
    check("t5_flags_clear", 64'({bus4.err_orphan, bus4.err_badsel}), 64'h0);
    step(1'b0, 1'b0, 3'd0, 1'b1, 32'h99);
    check("t5_no_valid", 64'(bus4.out_valid), 64'h0);
    check("t5_orphan", 64'(bus4.err_orphan), 64'h1);

    // Pointer wrap-around with rotating selects.
    do_reset();
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'((r * 3 + i) % 6), 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
        step(1'b0, 1'b0, 3'd0, 1'b1, 32'(r * 16 + i));
        check("t6_wrap_valid", 64'(bus4.out_valid), 64'(1 << ((r * 3 + i) % 6)));
      end
    end
    idle();
    check("t6_no_spurious", 64'(bus4.out_valid), 64'h0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      s = int'($urandom_range(0, 15));
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0),
           (s == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5)),
           ($urandom_range(0, 2) != 0), $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
